// File: rtl/bp_nonsynth_pkg.sv
// Shared types for the nonsynth cosim commit tracker.
package bp_nonsynth_pkg;

    localparam int unsigned reg_addr_width_gp = 5;
    localparam int unsigned vaddr_width_gp    = 39;
    localparam int unsigned instr_width_gp    = 32;
    localparam int unsigned dword_width_gp    = 64;

    typedef struct packed {
        logic                         trap;
        logic [vaddr_width_gp-1:0]    pc;
        logic [instr_width_gp-1:0]    instr;
        logic [dword_width_gp-1:0]    cause;
        logic                         need;
        logic                         fp;
        logic [reg_addr_width_gp-1:0] rd;
        logic                         done;
        logic [dword_width_gp-1:0]    data;
    } bp_nonsynth_commit_entry_s;

endpackage

// File: rtl/bp_nonsynth_oldest_match.sv
// Finds the oldest set bit of a match vector, counting from the head slot.
module bp_nonsynth_oldest_match
    import bp_nonsynth_pkg::*;
#(
    parameter int unsigned els_p   = 8,
    parameter int unsigned ptr_w_p = $clog2(els_p)
) (
    input  logic [els_p-1:0]   match_i,
    input  logic [ptr_w_p-1:0] head_i,
    output logic [ptr_w_p-1:0] idx_o,
    output logic               v_o
);

    logic [els_p-1:0]   rot;
    logic [ptr_w_p-1:0] slot;

    always_comb begin
        rot   = '0;
        slot  = '0;
        idx_o = '0;
        v_o   = 1'b0;
        for (int k = 0; k < int'(els_p); k++) begin
            slot   = ptr_w_p'(head_i + ptr_w_p'(k));
            rot[k] = match_i[slot];
        end
        // Scan youngest to oldest so the lowest offset wins.
        for (int k = int'(els_p) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                v_o   = 1'b1;
                idx_o = ptr_w_p'(head_i + ptr_w_p'(k));
            end
        end
    end

endmodule

// File: rtl/bp_nonsynth_commit_tracker.sv
// In-order joiner of retired instructions with their late register writebacks,
// presenting complete records to the cosim consumer over valid/yumi.
module bp_nonsynth_commit_tracker
    import bp_nonsynth_pkg::*;
#(
    parameter int unsigned vaddr_width_p = vaddr_width_gp,
    parameter int unsigned instr_width_p = instr_width_gp,
    parameter int unsigned dword_width_p = dword_width_gp,
    parameter int unsigned els_p         = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         commit_v_i,
    input  logic [vaddr_width_p-1:0]     commit_pc_i,
    input  logic [instr_width_p-1:0]     commit_instr_i,
    input  logic                         commit_rd_w_v_i,
    input  logic                         commit_fp_i,
    input  logic [reg_addr_width_gp-1:0] commit_rd_addr_i,
    input  logic                         interrupt_v_i,
    input  logic [dword_width_p-1:0]     cause_i,
    input  logic                         int_wb_v_i,
    input  logic [reg_addr_width_gp-1:0] int_wb_addr_i,
    input  logic [dword_width_p-1:0]     int_wb_data_i,
    input  logic                         fp_wb_v_i,
    input  logic [reg_addr_width_gp-1:0] fp_wb_addr_i,
    input  logic [dword_width_p-1:0]     fp_wb_data_i,
    output logic                         ready_o,
    output logic                         rec_v_o,
    output logic                         rec_trap_o,
    output logic [vaddr_width_p-1:0]     rec_pc_o,
    output logic [instr_width_p-1:0]     rec_instr_o,
    output logic [dword_width_p-1:0]     rec_wdata_o,
    output logic [dword_width_p-1:0]     rec_cause_o,
    input  logic                         rec_yumi_i,
    output logic                         overflow_err_o,
    output logic                         orphan_err_o,
    output logic                         proto_err_o
);

    localparam int unsigned ptr_w_lp = $clog2(els_p);
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

    bp_nonsynth_commit_entry_s entries_q [els_p];
    bp_nonsynth_commit_entry_s entries_d [els_p];
    logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic overflow_q, overflow_d, orphan_q, orphan_d, proto_q, proto_d;

    bp_nonsynth_commit_entry_s new_entry;
    logic enq_v, full, enq_ok, deq, int_wb_eff;
    logic [els_p-1:0] live_v, need_v, done_v, fp_v, int_match, fp_match;
    logic [reg_addr_width_gp-1:0] rd_v [els_p];
    logic [ptr_w_lp-1:0] int_idx, fp_idx;
    logic int_hit, fp_hit;

    // Build the incoming entry; an interrupt wins over a same-cycle commit.
    always_comb begin
        new_entry = '0;
        if (interrupt_v_i) begin
            new_entry.trap  = 1'b1;
            new_entry.cause = dword_width_gp'(cause_i);
        end else begin
            new_entry.pc    = vaddr_width_gp'(commit_pc_i);
            new_entry.instr = instr_width_gp'(commit_instr_i);
            new_entry.need  = commit_rd_w_v_i & ~(~commit_fp_i & (commit_rd_addr_i == '0));
            new_entry.fp    = commit_fp_i;
            new_entry.rd    = commit_rd_addr_i;
        end
        enq_v      = commit_v_i | interrupt_v_i;
        full       = (count_q == cnt_w_lp'(els_p));
        enq_ok     = enq_v & ~full;
        rec_v_o    = (count_q != '0) & (~entries_q[head_q].need | entries_q[head_q].done);
        deq        = rec_yumi_i & rec_v_o;
        int_wb_eff = int_wb_v_i & (int_wb_addr_i != '0);
    end

    // Candidate view of each slot, with this cycle's enqueue as the youngest.
    always_comb begin
        live_v    = '0;
        need_v    = '0;
        done_v    = '0;
        fp_v      = '0;
        int_match = '0;
        fp_match  = '0;
        for (int i = 0; i < int'(els_p); i++) begin
            live_v[i] = cnt_w_lp'(ptr_w_lp'(ptr_w_lp'(i) - head_q)) < count_q;
            need_v[i] = entries_q[i].need;
            done_v[i] = entries_q[i].done;
            fp_v[i]   = entries_q[i].fp;
            rd_v[i]   = entries_q[i].rd;
            if (enq_ok && (ptr_w_lp'(i) == tail_q)) begin
                live_v[i] = 1'b1;
                need_v[i] = new_entry.need;
                done_v[i] = 1'b0;
                fp_v[i]   = new_entry.fp;
                rd_v[i]   = new_entry.rd;
            end
            int_match[i] = live_v[i] & need_v[i] & ~done_v[i] & ~fp_v[i] & (rd_v[i] == int_wb_addr_i);
            fp_match[i]  = live_v[i] & need_v[i] & ~done_v[i] &  fp_v[i] & (rd_v[i] == fp_wb_addr_i);
        end
    end

    bp_nonsynth_oldest_match #(.els_p(els_p), .ptr_w_p(ptr_w_lp)) int_sel (
        .match_i(int_match), .head_i(head_q), .idx_o(int_idx), .v_o(int_hit)
    );

    bp_nonsynth_oldest_match #(.els_p(els_p), .ptr_w_p(ptr_w_lp)) fp_sel (
        .match_i(fp_match), .head_i(head_q), .idx_o(fp_idx), .v_o(fp_hit)
    );

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (enq_ok) begin
            entries_d[tail_q] = new_entry;
            tail_d            = tail_q + ptr_w_lp'(1);
        end
        if (int_wb_eff && int_hit) begin
            entries_d[int_idx].done = 1'b1;
            entries_d[int_idx].data = dword_width_gp'(int_wb_data_i);
        end
        if (fp_wb_v_i && fp_hit) begin
            entries_d[fp_idx].done = 1'b1;
            entries_d[fp_idx].data = dword_width_gp'(fp_wb_data_i);
        end
        if (deq) begin
            head_d = head_q + ptr_w_lp'(1);
        end
        count_d    = count_q + cnt_w_lp'(enq_ok) - cnt_w_lp'(deq);
        overflow_d = overflow_q | (enq_v & full);
        orphan_d   = orphan_q | (int_wb_eff & ~int_hit) | (fp_wb_v_i & ~fp_hit);
        proto_d    = proto_q | (commit_v_i & interrupt_v_i) | (rec_yumi_i & ~rec_v_o);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            orphan_q   <= 1'b0;
            proto_q    <= 1'b0;
            for (int i = 0; i < int'(els_p); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            orphan_q   <= orphan_d;
            proto_q    <= proto_d;
            entries_q  <= entries_d;
        end
    end

    always_comb begin
        ready_o        = (count_q != cnt_w_lp'(els_p));
        rec_trap_o     = entries_q[head_q].trap;
        rec_pc_o       = vaddr_width_p'(entries_q[head_q].pc);
        rec_instr_o    = instr_width_p'(entries_q[head_q].instr);
        rec_cause_o    = dword_width_p'(entries_q[head_q].cause);
        rec_wdata_o    = entries_q[head_q].need ? dword_width_p'(entries_q[head_q].data) : '0;
        overflow_err_o = overflow_q;
        orphan_err_o   = orphan_q;
        proto_err_o    = proto_q;
    end

endmodule

// File: doc/bp_nonsynth_commit_tracker.md
# bp_nonsynth_commit_tracker

Non-synthesizable, in-order commit/writeback joiner feeding the Dromajo cosim checker. It buffers retired instructions and interrupts from the backend. It pairs each register-writing commit with its late-arriving integer or FP writeback, including long-latency pipes, and presents complete records in program order over a valid/yumi interface. The consumer can then step the reference model without knowledge of pipe latencies.

## Interface
- vaddr_width_p, 39, commit PC width
- instr_width_p, 32, instruction width
- dword_width_p, 64, writeback data and cause width
- els_p, 8, record buffer depth; power of two, ≥2
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- commit_v_i  in  1  instruction retired this cycle
- commit_pc_i / commit_instr_i  in  vaddr_width_p / instr_width_p  retired PC, encoding
- commit_rd_w_v_i  in  1  retired instruction writes a destination register
- commit_fp_i  in  1  destination is FP file (else integer)
- commit_rd_addr_i  in  5  destination register
- interrupt_v_i  in  1  trap taken this cycle
- cause_i  in  dword_width_p  trap cause
- int_wb_v_i / int_wb_addr_i / int_wb_data_i  in  1 / 5 / dword_width_p  integer RF write
- fp_wb_v_i / fp_wb_addr_i / fp_wb_data_i  in  1 / 5 / dword_width_p  FP RF write
- ready_o  out  1  buffer not full (count < els_p)
- rec_v_o  out  1  head record complete
- rec_trap_o  out  1  record is an interrupt
- rec_pc_o / rec_instr_o / rec_wdata_o / rec_cause_o  out  head fields
- rec_yumi_i  in  1  consumer takes head; legal only when rec_v_o
- overflow_err_o / orphan_err_o / proto_err_o  out  1  sticky error flags

## Operation
- Circular buffer with head/tail pointers of clog2(els_p) bits, wrapping naturally; count of clog2(els_p+1) bits.
- Entry fields: trap, pc, instr, cause, need, fp, rd, done, data.
- Enqueue at tail on commit_v_i | interrupt_v_i.
  - Interrupt entry: trap=1, need=0.
  - Commit entry: need = commit_rd_w_v_i & ~(~commit_fp_i & rd==0); done=0, data=0.
- Both commit_v_i and interrupt_v_i high in one cycle: enqueue the interrupt only, set proto_err_o.
- Enqueue when count==els_p: drop the entry, set overflow_err_o, even if rec_yumi_i is high the same cycle.
- Writeback match, done separately for int and FP ports:
  - Target is the oldest entry (from head) with need & ~done, matching fp, and rd == wb addr.
  - The entry being enqueued this cycle is included as the youngest candidate.
  - On a match: set done, capture data.
  - No match: set orphan_err_o and discard the data.
  - Int writes to x0 are ignored.
- Head complete = count≠0 & (~need | done). rec_v_o equals head complete. Fields come combinationally from the head entry; rec_wdata_o is 0 when need=0.
- rec_yumi_i advances head and decrements count. Simultaneous enqueue and dequeue leaves count unchanged.
- rec_yumi_i while rec_v_o=0 is ignored and sets proto_err_o.
- Error flags clear only on reset.

## Timing
- Reset (async assert, sync release): pointers, count, all entry valid/done bits, and all error flags go to 0. rec_v_o=0, ready_o=1, all rec_* fields 0.
- Enqueue is registered. A need=0 commit at cycle t gives rec_v_o at t+1, if it is at the head.
- A need=1 commit at t with a matching writeback at cycle w≥t gives rec_v_o at max(t,w)+1.
- A writeback that arrives before its commit is enqueued counts as orphan.
- Throughput: one enqueue and one dequeue per cycle.
- ready_o depends only on registered count, with no combinational path from rec_yumi_i.
- Reset asserted mid-operation discards all buffered records immediately.

## Structure
- Shared package bp_nonsynth_pkg holds:
  - typedef bp_nonsynth_commit_entry_s with the fields above
  - localparam for register address width (5)
- Sub-module bp_nonsynth_oldest_match: given an els_p match vector and the head pointer, rotate, priority-encode, and return an index plus valid. It is instantiated twice, for int and FP.
- Target size: about 250 lines.

## Test plan
- Non-writing commit, pc=0x8000_0000, yumi held high → rec_v_o one cycle later, wdata 0, no errors.
- Commit int rd=5 at t, int_wb addr 5 data 0xDEAD at t+4 → rec_v_o at t+5 with wdata 0xDEAD. A younger non-writing commit stays behind it (in-order).
- Two commits both to FP f3, then two FP writebacks 0x1 and 0x2 → records emerge with 0x1 then 0x2; an int wb to x3 in between sets orphan_err_o.
- Fill 8 non-writing commits with yumi low → ready_o=0. A 9th commit sets overflow_err_o. Drain gives exactly 8 records in order, including across pointer wrap.
- commit_v_i and interrupt_v_i together with cause 0x8000_0000_0000_0007 → a single record, rec_trap_o=1, cause matches, proto_err_o=1.
- Reset asserted with 3 pending entries → outputs 0 asynchronously. After release, ready_o=1 and rec_v_o=0.
